enc_quad_filter: RTL

Front end of each encoder channel. Synchronizes the raw A/B lines from the QLA connector, rejects glitches shorter than a programmable number of `sysclk` cycles, and decodes the clean quadrature signals into a direction bit and a preloadable position count. Its filtered `a`, `b` and `dir` outputs drive the encoder period/acceleration stage directly; `pos` and `err` go to the register file.

---
 rtl/enc_pkg.sv | 38 +++
 rtl/enc_input_filter.sv | 55 +++++
 rtl/enc_quad_filter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder quadrature front end.
package enc_pkg;

  // Quadrature states, bit order {a, b}
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef enum logic [1:0] {NONE, FWD, REV, ILLEGAL} step_t;

  typedef enum logic {ST_INIT, ST_RUN} ctrl_state_t;

  // Bits needed to hold a counter value in 0..max_val (at least 1)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Classify a transition between two consecutive filtered {a,b} samples
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = NONE;
    if (prev == cur) begin
      s = NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = ILLEGAL;
    end else begin
      case (prev)
        Q00:     s = (cur == Q10) ? FWD : REV;
        Q10:     s = (cur == Q11) ? FWD : REV;
        Q11:     s = (cur == Q01) ? FWD : REV;
        default: s = (cur == Q00) ? FWD : REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one encoder line.
module enc_input_filter
  import enc_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic init,
  output logic filt
);

  localparam int CW = cnt_width(FILT_LEN - 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous line into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the filtered value once the synchronized value has differed for FILT_LEN cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (init) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else if (r_sync2 != r_filt) begin
      if (r_cnt == LAST) begin
        r_filt <= ~r_filt;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign filt = r_filt;

endmodule

// File: rtl/enc_quad_filter.sv
// Encoder channel front end: filtered A/B, quadrature decode, position and error tracking.
module enc_quad_filter
  import enc_pkg::*;
#(
  parameter int                   FILT_LEN  = 4,
  parameter int                   POS_WIDTH = 24,
  parameter logic [POS_WIDTH-1:0] PRELOAD   = 24'h800000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 preload_wr,
  input  logic [POS_WIDTH-1:0] preload_val,
  input  logic                 err_clr,
  output logic                 a,
  output logic                 b,
  output logic                 dir,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 edge_strobe,
  output logic                 err
);

  localparam int IW = cnt_width(FILT_LEN + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILT_LEN + 1);

  ctrl_state_t          r_state;
  ctrl_state_t          w_state_nxt;
  logic [IW-1:0]        r_init_cnt;
  logic [IW-1:0]        w_init_cnt_nxt;
  logic                 w_init;
  logic                 w_init_done;
  logic                 w_a;
  logic                 w_b;
  logic [1:0]           w_cur;
  logic [1:0]           r_prev;
  step_t                w_step;
  logic                 r_dir;
  logic                 r_edge;
  logic                 r_err;
  logic [POS_WIDTH-1:0] r_pos;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a_in),
    .init  (w_init),
    .filt  (w_a)
  );

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b_in),
    .init  (w_init),
    .filt  (w_b)
  );

  assign w_cur = {w_a, w_b};

  // Control state and INIT duration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Next state: INIT lasts FILT_LEN+2 cycles, then RUN until reset
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init         = 1'b0;
    w_init_done    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init = 1'b1;
        if (r_init_cnt == INIT_LAST) begin
          w_init_done = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + IW'(1);
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Step classification, only while running
  always_comb begin
    w_step = NONE;
    if (r_state == ST_RUN) begin
      w_step = decode_step(r_prev, w_cur);
    end
  end

  // Previous-state register, seeded on the last INIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else if (w_init_done || (r_state == ST_RUN)) begin
      r_prev <= w_cur;
    end
  end

  // Position, direction, strobe and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos  <= PRELOAD;
      r_dir  <= 1'b0;
      r_edge <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_edge <= (w_step == FWD) || (w_step == REV);
      if (w_step == FWD) begin
        r_dir <= 1'b1;
      end else if (w_step == REV) begin
        r_dir <= 1'b0;
      end
      if (preload_wr) begin
        r_pos <= preload_val;
      end else if (w_step == FWD) begin
        r_pos <= r_pos + POS_WIDTH'(1);
      end else if (w_step == REV) begin
        r_pos <= r_pos - POS_WIDTH'(1);
      end
      if (w_step == ILLEGAL) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign a           = w_a;
  assign b           = w_b;
  assign dir         = r_dir;
  assign pos         = r_pos;
  assign edge_strobe = r_edge;
  assign err         = r_err;

endmodule
